// File: rtl/lane_runner_ctrl.sv
// Multi-lane runner game controller: tick timer, LFSR obstacle spawner, per-lane
// scroll maps, collision check, saturating score and session high score.
module lane_runner_ctrl #(
    parameter int LANES        = 4,
    parameter int VIEW         = 6,
    parameter int PLAYER_COL   = 4,
    parameter int TICK_W       = 10,
    parameter int TICK_INIT    = 300,
    parameter int TICK_MIN     = 50,
    parameter int SPAWN_THRESH = 64,
    parameter int MIN_GAP      = 2,
    parameter int SCORE_MAX    = 9999
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       LoggedIn,
    input  logic                       BtnUp,
    input  logic                       BtnDown,
    output logic [LANES*VIEW-1:0]      LaneBits,
    output logic [$clog2(LANES)-1:0]   PlayerLane,
    output logic                       GameTick,
    output logic [2:0]                 GameState,
    output logic [13:0]                GameScore,
    output logic [13:0]                HighScore,
    output logic [TICK_W-1:0]          TickPeriod
);
    localparam int LW = $clog2(LANES);
    localparam int GW = $clog2(MIN_GAP + 1) + 1;
    localparam logic [TICK_W-1:0] T_INIT  = TICK_W'(TICK_INIT);
    localparam logic [TICK_W-1:0] T_MIN   = TICK_W'(TICK_MIN);
    localparam logic [GW-1:0]     GAP_MAX = GW'(MIN_GAP);
    localparam logic [8:0]        SP_THR  = 9'(SPAWN_THRESH);
    localparam logic [7:0]        LANES8  = 8'(LANES);
    localparam logic [13:0]       S_MAX   = 14'(SCORE_MAX);
    localparam logic [LW-1:0]     TOP     = LW'(LANES - 1);

    typedef enum logic [2:0] {S_IDLE = 3'd0, S_WAIT = 3'd1, S_PLAY = 3'd2, S_END = 3'd3} state_t;
    typedef enum logic [1:0] {M_NONE, M_UP, M_DN} move_t;

    state_t                     r_state, w_state_n;
    logic [LANES-1:0][VIEW-1:0] r_lanes, w_lanes_n, w_shift;
    logic [LW-1:0]              r_lane, w_lane_n, w_tgt;
    logic [TICK_W-1:0]          r_cnt, w_cnt_n, r_period, w_period_n;
    logic [GW-1:0]              r_gap, w_gap_n;
    logic [13:0]                r_score, w_score_n, r_high, w_high_n;
    logic [15:0]                r_lfsr, w_lfsr_n;
    logic                       r_up_q, r_dn_q;
    move_t                      r_pend, w_pend_n, w_edge_mv, w_req;
    logic                       w_up_e, w_dn_e, w_any, w_tick, w_spawn, w_hit, w_mv_ok;
    logic [7:0]                 w_sp_lane8;
    logic [LANES-1:0]           w_new;

    assign w_up_e    = BtnUp & ~r_up_q;
    assign w_dn_e    = BtnDown & ~r_dn_q;
    assign w_any     = w_up_e | w_dn_e;
    assign w_edge_mv = (w_up_e && !w_dn_e) ? M_UP : ((w_dn_e && !w_up_e) ? M_DN : M_NONE);

    // Galois form of x^16+x^15+x^13+x^4+1; maximal length, so never reaches zero
    assign w_lfsr_n   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hD008 : 16'h0000);
    assign w_tick     = LoggedIn && (r_state == S_PLAY) && (r_cnt == r_period - 1'b1);
    assign w_spawn    = ({1'b0, r_lfsr[7:0]} < SP_THR) && (r_gap >= GAP_MAX);
    assign w_sp_lane8 = r_lfsr[15:8] % LANES8;

    always_comb begin
        w_new   = '0;
        w_shift = '0;
        for (int k = 0; k < LANES; k++) begin
            w_new[k]   = w_spawn && (w_sp_lane8 == 8'(k));
            w_shift[k] = {w_new[k], r_lanes[k][VIEW-1:1]};
        end
    end

    assign w_hit = w_shift[r_lane][PLAYER_COL];

    always_comb begin
        w_req   = w_any ? w_edge_mv : r_pend;
        w_tgt   = (w_req == M_UP) ? r_lane + 1'b1 : r_lane - 1'b1;
        w_mv_ok = ((w_req == M_UP) && (r_lane != TOP)) || ((w_req == M_DN) && (r_lane != '0));
    end

    always_comb begin
        w_state_n  = r_state;
        w_lanes_n  = r_lanes;
        w_lane_n   = r_lane;
        w_cnt_n    = r_cnt;
        w_period_n = r_period;
        w_gap_n    = r_gap;
        w_pend_n   = r_pend;
        w_score_n  = r_score;
        w_high_n   = r_high;
        if (!LoggedIn) begin
            w_state_n = S_IDLE;
            w_lanes_n = '0;
            w_pend_n  = M_NONE;
        end else begin
            case (r_state)
                S_IDLE: w_state_n = S_WAIT;
                S_WAIT: if (w_any) begin
                    w_state_n  = S_PLAY;
                    w_lanes_n  = '0;
                    w_score_n  = '0;
                    w_lane_n   = '0;
                    w_period_n = T_INIT;
                    w_cnt_n    = '0;
                    w_gap_n    = GAP_MAX;
                    w_pend_n   = M_NONE;
                end
                S_PLAY: if (w_tick) begin
                    w_cnt_n   = '0;
                    w_lanes_n = w_shift;
                    if (w_spawn) begin
                        w_gap_n = '0;
                        if (r_period > T_MIN) w_period_n = r_period - 1'b1;
                    end else if (r_gap < GAP_MAX) begin
                        w_gap_n = r_gap + 1'b1;
                    end
                    if (r_score < S_MAX) w_score_n = r_score + 1'b1;
                    // moves requested on a scroll step are judged against the shifted map
                    w_pend_n = w_edge_mv;
                    if (w_hit) w_state_n = S_END;
                end else begin
                    w_cnt_n  = r_cnt + 1'b1;
                    w_pend_n = M_NONE;
                    if (w_mv_ok) begin
                        if (r_lanes[w_tgt][PLAYER_COL]) w_state_n = S_END;
                        else                            w_lane_n  = w_tgt;
                    end
                end
                S_END:   if (w_any) w_state_n = S_WAIT;
                default: w_state_n = S_IDLE;
            endcase
        end
        if ((w_state_n == S_END) && (r_state != S_END) && (w_score_n > r_high))
            w_high_n = w_score_n;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_lanes  <= '0;
            r_lane   <= '0;
            r_cnt    <= '0;
            r_period <= T_INIT;
            r_gap    <= GAP_MAX;
            r_score  <= '0;
            r_high   <= '0;
            r_lfsr   <= 16'hACE1;
            r_up_q   <= 1'b0;
            r_dn_q   <= 1'b0;
            r_pend   <= M_NONE;
        end else begin
            r_state  <= w_state_n;
            r_lanes  <= w_lanes_n;
            r_lane   <= w_lane_n;
            r_cnt    <= w_cnt_n;
            r_period <= w_period_n;
            r_gap    <= w_gap_n;
            r_score  <= w_score_n;
            r_high   <= w_high_n;
            r_lfsr   <= w_lfsr_n;
            r_up_q   <= BtnUp;
            r_dn_q   <= BtnDown;
            r_pend   <= w_pend_n;
        end
    end

    assign LaneBits   = r_lanes;
    assign PlayerLane = r_lane;
    assign GameTick   = w_tick;
    assign GameState  = r_state;
    assign GameScore  = r_score;
    assign HighScore  = r_high;
    assign TickPeriod = r_period;
endmodule

// File: tb/tb_lane_runner_ctrl.sv
// Bench for lane_runner_ctrl: three instances (default, never-spawn, always-spawn)
// share stimulus; the always-spawn map is predicted by a bench-side game model.
module tb_lane_runner_ctrl;
    logic Clk = 1'b0, Rst = 1'b1, LoggedIn = 1'b0, BtnUp = 1'b0, BtnDown = 1'b0;
    always #5 Clk = ~Clk;

    logic [23:0] d_lanes, n_lanes, s_lanes;
    logic [1:0]  d_lane, n_lane, s_lane;
    logic        d_tick, n_tick, s_tick;
    logic [2:0]  d_st, n_st, s_st;
    logic [13:0] d_score, n_score, s_score, d_high, n_high, s_high;
    logic [9:0]  d_per, n_per, s_per;

    lane_runner_ctrl u_def (
        .Clk(Clk), .Rst(Rst), .LoggedIn(LoggedIn), .BtnUp(BtnUp), .BtnDown(BtnDown),
        .LaneBits(d_lanes), .PlayerLane(d_lane), .GameTick(d_tick), .GameState(d_st),
        .GameScore(d_score), .HighScore(d_high), .TickPeriod(d_per));

    lane_runner_ctrl #(.TICK_INIT(4), .TICK_MIN(2), .SPAWN_THRESH(0)) u_nsp (
        .Clk(Clk), .Rst(Rst), .LoggedIn(LoggedIn), .BtnUp(BtnUp), .BtnDown(BtnDown),
        .LaneBits(n_lanes), .PlayerLane(n_lane), .GameTick(n_tick), .GameState(n_st),
        .GameScore(n_score), .HighScore(n_high), .TickPeriod(n_per));

    lane_runner_ctrl #(.TICK_INIT(6), .TICK_MIN(4), .SPAWN_THRESH(256), .MIN_GAP(0)) u_spn (
        .Clk(Clk), .Rst(Rst), .LoggedIn(LoggedIn), .BtnUp(BtnUp), .BtnDown(BtnDown),
        .LaneBits(s_lanes), .PlayerLane(s_lane), .GameTick(s_tick), .GameState(s_st),
        .GameScore(s_score), .HighScore(s_high), .TickPeriod(s_per));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] lanes;
        logic [13:0] score;
        logic [9:0]  per;
    } exp_t;
    exp_t sbq[$];

    // Bench game model for the always-spawn instance
    logic [15:0] m_lfsr;
    logic [5:0]  m_map[4];
    int          m_lane, m_score, m_high, m_period;
    bit          m_ended;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hD008 : 16'h0000);
    end

    task automatic spn_tick();
        int   L;
        exp_t e;
        L = int'(m_lfsr[15:8]) % 4;
        for (int k = 0; k < 4; k++) m_map[k] = {(k == L), m_map[k][5:1]};
        if (m_score < 9999) m_score++;
        if (m_period > 4) m_period--;
        if (m_map[m_lane][4]) begin
            m_ended = 1'b1;
            if (m_score > m_high) m_high = m_score;
        end
        for (int k = 0; k < 4; k++) e.lanes[k*6 +: 6] = m_map[k];
        e.score = 14'(m_score);
        e.per   = 10'(m_period);
        sbq.push_back(e);
    endtask

    task automatic start_game();
        @(negedge Clk); LoggedIn = 1'b0; BtnUp = 1'b0; BtnDown = 1'b0;
        @(negedge Clk); LoggedIn = 1'b1;
        @(negedge Clk); BtnDown = 1'b1;
        @(negedge Clk); BtnDown = 1'b0;
        for (int k = 0; k < 4; k++) m_map[k] = '0;
        m_lane = 0; m_score = 0; m_period = 6; m_ended = 1'b0;
        sbq.delete();
    endtask

    task automatic pulse(input logic up, input logic dn);
        BtnUp = up; BtnDown = dn;
        @(negedge Clk); BtnUp = 1'b0; BtnDown = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1; LoggedIn = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (d_st !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", d_st); end
        checks++; if (d_lanes !== 24'd0) begin failures++; $display("FAIL rst_lanes got=%h exp=0", d_lanes); end
        checks++; if (d_lane !== 2'd0) begin failures++; $display("FAIL rst_lane got=%0d exp=0", d_lane); end
        checks++; if (d_tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", d_tick); end
        checks++; if (d_score !== 14'd0 || d_high !== 14'd0) begin failures++; $display("FAIL rst_scores got=%0d/%0d exp=0/0", d_score, d_high); end
        checks++; if (d_per !== 10'd300) begin failures++; $display("FAIL rst_period got=%0d exp=300", d_per); end
        LoggedIn = 1'b1;
        @(negedge Clk);
        checks++; if (d_st !== 3'd1) begin failures++; $display("FAIL login_wait got=%0d exp=1", d_st); end
        BtnDown = 1'b1;
        @(negedge Clk);
        BtnDown = 1'b0;
        checks++; if (d_st !== 3'd2) begin failures++; $display("FAIL start_play got=%0d exp=2", d_st); end
        checks++; if (d_score !== 14'd0 || d_per !== 10'd300) begin failures++; $display("FAIL start_vals got=%0d/%0d exp=0/300", d_score, d_per); end
    endtask

    task automatic test_tick();
        int sq[$];
        int exp_score = 0;
        start_game();
        for (int i = 0; i <= 40; i++) begin
            if (sq.size() > 0) begin
                int es = sq.pop_front();
                checks++; if (n_score !== 14'(es)) begin failures++; $display("FAIL tick_score got=%0d exp=%0d", n_score, es); end
            end
            checks++;
            if (n_tick !== ((i % 4) == 3)) begin failures++; $display("FAIL tick_timing cyc=%0d got=%b exp=%b", i, n_tick, (i % 4) == 3); end
            if ((i % 4) == 3) sq.push_back(++exp_score);
            @(negedge Clk);
        end
        checks++; if (n_score !== 14'd10) begin failures++; $display("FAIL tick_final_score got=%0d exp=10", n_score); end
        checks++; if (n_lanes !== 24'd0 || n_per !== 10'd4) begin failures++; $display("FAIL tick_final_map got=%h/%0d exp=0/4", n_lanes, n_per); end
    endtask

    task automatic test_moves();
        int el = 0;
        start_game();
        pulse(1'b0, 1'b1);
        checks++; if (n_lane !== 2'd0) begin failures++; $display("FAIL move_down_at0 got=%0d exp=0", n_lane); end
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0);
            if (el < 3) el++;
            checks++; if (n_lane !== 2'(el)) begin failures++; $display("FAIL move_up%0d got=%0d exp=%0d", i, n_lane, el); end
        end
        pulse(1'b1, 1'b1);
        checks++; if (n_lane !== 2'd3) begin failures++; $display("FAIL move_both got=%0d exp=3", n_lane); end
        pulse(1'b0, 1'b1);
        checks++; if (n_lane !== 2'd2) begin failures++; $display("FAIL move_down got=%0d exp=2", n_lane); end
    endtask

    task automatic test_spawn();
        exp_t e;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        m_high = 0;
        start_game();
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++; if (s_lanes !== e.lanes) begin failures++; $display("FAIL spawn_map got=%h exp=%h", s_lanes, e.lanes); end
                checks++; if (s_score !== e.score) begin failures++; $display("FAIL spawn_score got=%0d exp=%0d", s_score, e.score); end
                checks++; if (s_per !== e.per) begin failures++; $display("FAIL spawn_period got=%0d exp=%0d", s_per, e.per); end
            end
            if (m_ended) break;
            if (s_tick) spn_tick();
        end
        checks++; if (!m_ended) begin failures++; $display("FAIL spawn_timeout got=no_collision exp=collision"); end
        checks++; if (s_st !== 3'd3) begin failures++; $display("FAIL spawn_end got=%0d exp=3", s_st); end
        checks++; if (s_high !== 14'(m_high)) begin failures++; $display("FAIL spawn_high got=%0d exp=%0d", s_high, m_high); end
        repeat (8) @(negedge Clk);
        checks++; if (s_score !== 14'(m_score) || s_tick !== 1'b0) begin failures++; $display("FAIL end_frozen got=%0d/%b exp=%0d/0", s_score, s_tick, m_score); end
        checks++; if (s_lanes !== e.lanes) begin failures++; $display("FAIL end_map_held got=%h exp=%h", s_lanes, e.lanes); end
    endtask

    task automatic test_pending();
        exp_t e;
        int   phase = 0;
        int   tgt;
        start_game();
        for (int c = 0; c < 1500 && phase < 2; c++) begin
            @(negedge Clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++; if (s_lanes !== e.lanes) begin failures++; $display("FAIL pend_map got=%h exp=%h", s_lanes, e.lanes); end
                checks++; if (s_score !== e.score) begin failures++; $display("FAIL pend_score got=%0d exp=%0d", s_score, e.score); end
            end
            if (m_ended) begin
                start_game();
                continue;
            end
            if (s_tick) begin
                tgt = m_lane + 1;
                spn_tick();
                if (!m_ended && m_lane < 3 && ((phase == 0) ? !m_map[tgt][4] : m_map[tgt][4])) begin
                    BtnUp = 1'b1;
                    @(negedge Clk);
                    BtnUp = 1'b0;
                    checks++; if (s_lane !== 2'(m_lane)) begin failures++; $display("FAIL pend_hold got=%0d exp=%0d", s_lane, m_lane); end
                    @(negedge Clk);
                    if (phase == 1) begin
                        m_ended = 1'b1;
                        if (m_score > m_high) m_high = m_score;
                        checks++; if (s_st !== 3'd3 || s_lane !== 2'(m_lane)) begin failures++; $display("FAIL pend_block got=%0d/%0d exp=3/%0d", s_st, s_lane, m_lane); end
                    end else begin
                        m_lane = tgt;
                        checks++; if (s_st !== 3'd2 || s_lane !== 2'(m_lane)) begin failures++; $display("FAIL pend_apply got=%0d/%0d exp=2/%0d", s_st, s_lane, m_lane); end
                    end
                    phase++;
                end
            end
        end
        checks++; if (phase != 2) begin failures++; $display("FAIL pend_timeout got=phase%0d exp=phase2", phase); end
    endtask

    task automatic test_logout();
        start_game();
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (s_tick) begin spn_tick(); break; end
        end
        @(negedge Clk);
        LoggedIn = 1'b0;
        @(negedge Clk);
        checks++; if (s_st !== 3'd0 || s_lanes !== 24'd0) begin failures++; $display("FAIL logout got=%0d/%h exp=0/0", s_st, s_lanes); end
        checks++; if (s_high !== 14'(m_high)) begin failures++; $display("FAIL logout_high got=%0d exp=%0d", s_high, m_high); end
        start_game();
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (s_tick) begin spn_tick(); break; end
        end
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        checks++; if (s_st !== 3'd0 || s_lanes !== 24'd0 || s_lane !== 2'd0) begin failures++; $display("FAIL async_rst_state got=%0d/%h/%0d exp=0/0/0", s_st, s_lanes, s_lane); end
        checks++; if (s_score !== 14'd0 || s_high !== 14'd0 || d_high !== 14'd0) begin failures++; $display("FAIL async_rst_scores got=%0d/%0d/%0d exp=0/0/0", s_score, s_high, d_high); end
        checks++; if (s_per !== 10'd6 || s_tick !== 1'b0) begin failures++; $display("FAIL async_rst_timer got=%0d/%b exp=6/0", s_per, s_tick); end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick();
        test_moves();
        test_spawn();
        test_pending();
        test_logout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
